rv32im_alu: RTL and testbench

- Integer execute unit of the pipelined RV32 core.
- Computes RV32I register/immediate ALU results and RV32M multiply/divide results from funct3/funct7.
- Single-cycle ops complete combinationally. Multiply and divide are multi-cycle, using a start pulse (ready) and a completion flag (done).
- Sits in the EX stage; EX holds operands stable until done.

---
 rtl/rv32im_alu_pkg.sv | 51 +++++
 rtl/rv32im_alu_divider.sv | 121 ++++++++++++
 rtl/rv32im_alu.sv | 142 ++++++++++++++
 tb/tb_rv32im_alu.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32im_alu_pkg.sv
// Shared constants, FSM state type and the restoring-division step for rv32im_alu.
package rv32im_alu_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned DIV_ITERS  = 32;
    localparam int unsigned CNT_W      = 6;
    localparam int unsigned FUNCT7_ALT = 5;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // Base op funct3 encodings
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // M-extension funct3 encodings
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {IDLE, MUL, DIV, HOLD} state_e;

    // Partial remainder and quotient/dividend shift register of the divider
    typedef struct packed {
        logic [XLEN-1:0] rem;
        logic [XLEN-1:0] quo;
    } div_acc_t;

    // One restoring iteration: shift in the next dividend bit, trial-subtract the divisor
    function automatic div_acc_t div_step(input div_acc_t acc, input logic [XLEN-1:0] dsor);
        logic [XLEN:0] sh;
        logic [XLEN:0] diff;
        div_acc_t      nxt;
        sh       = {acc.rem, acc.quo[XLEN-1]};
        diff     = sh - {1'b0, dsor};
        nxt.quo  = {acc.quo[XLEN-2:0], ~diff[XLEN]};
        nxt.rem  = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
        return nxt;
    endfunction

endpackage

// File: rtl/rv32im_alu_divider.sv
// Serial 32-bit restoring divider with RISC-V sign and special-case handling.
//   start      : load operands and perform the first iteration
//   is_signed  : DIV/REM semantics when set, DIVU/REMU otherwise
//   dividend, divisor : operands, sampled on start
//   quotient, remainder : sign-corrected results, valid once valid is high
//   busy       : iterations in progress
//   valid      : all 32 iterations done; results hold until the next start
module rv32im_alu_divider
    import rv32im_alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            busy,
    output logic            valid
);

    div_acc_t         acc_q, acc_d;
    logic [XLEN-1:0]  dsor_q, dsor_d;
    logic [XLEN-1:0]  dvnd_q, dvnd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             by_zero_q, by_zero_d;
    logic             ovf_q, ovf_d;

    logic [XLEN-1:0]  a_mag;
    logic [XLEN-1:0]  b_mag;
    div_acc_t         acc_init;

    // Next-state: load + first iteration on start, then one iteration per cycle
    always_comb begin
        acc_d     = acc_q;
        dsor_d    = dsor_q;
        dvnd_d    = dvnd_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        valid_d   = valid_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        by_zero_d = by_zero_q;
        ovf_d     = ovf_q;

        a_mag        = (is_signed && dividend[XLEN-1]) ? -dividend : dividend;
        b_mag        = (is_signed && divisor[XLEN-1])  ? -divisor  : divisor;
        acc_init.rem = '0;
        acc_init.quo = a_mag;

        if (start) begin
            acc_d     = div_step(acc_init, b_mag);
            dsor_d    = b_mag;
            dvnd_d    = dividend;
            cnt_d     = CNT_W'(1);
            busy_d    = 1'b1;
            valid_d   = 1'b0;
            neg_quo_d = is_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
            neg_rem_d = is_signed && dividend[XLEN-1];
            by_zero_d = (divisor == '0);
            ovf_d     = is_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}})
                                  && (divisor == '1);
        end else if (busy_q) begin
            acc_d = div_step(acc_q, dsor_q);
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
                busy_d  = 1'b0;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            dsor_q    <= '0;
            dvnd_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            by_zero_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            dsor_q    <= dsor_d;
            dvnd_q    <= dvnd_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            by_zero_q <= by_zero_d;
            ovf_q     <= ovf_d;
        end
    end

    // Sign fixup and special cases; the parent latches these on its final edge
    always_comb begin
        if (by_zero_q) begin
            quotient  = '1;
            remainder = dvnd_q;
        end else if (ovf_q) begin
            quotient  = {1'b1, {(XLEN-1){1'b0}}};
            remainder = '0;
        end else begin
            quotient  = neg_quo_q ? -acc_q.quo : acc_q.quo;
            remainder = neg_rem_q ? -acc_q.rem : acc_q.rem;
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;

endmodule

// File: rtl/rv32im_alu.sv
// RV32IM integer execute unit: combinational base ALU, 1-edge multiply, 33-edge divide.
//   clk, rst      : clock, synchronous active-high reset
//   in1, in2      : operands (in2 may be the sign-extended immediate)
//   is_imm        : OP-IMM instruction
//   funct3/funct7 : operation select
//   ready         : start pulse in the first EX cycle of an instruction
//   out, done     : result and its validity
module rv32im_alu
    import rv32im_alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic            is_imm,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic            ready,
    output logic [XLEN-1:0] out,
    output logic            done
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            is_m;
    logic            is_mul;
    logic            is_div;
    logic [XLEN-1:0] base_res;
    logic [4:0]      shamt;
    logic signed [XLEN:0] mul_a;
    logic signed [XLEN:0] mul_b;
    logic [2*XLEN-1:0]    prod;
    logic [XLEN-1:0] mul_res;
    logic            div_signed;
    logic            div_rem_sel;
    logic            div_start;
    logic [XLEN-1:0] div_quo;
    logic [XLEN-1:0] div_rem;
    logic            div_busy;
    logic            div_valid;

    assign is_m   = !is_imm && (funct7 == FUNCT7_MULDIV);
    assign is_mul = is_m && !funct3[2];
    assign is_div = is_m && funct3[2];
    assign shamt  = in2[4:0];

    // Base RV32I datapath
    always_comb begin
        base_res = '0;
        case (funct3)
            F3_ADD:  base_res = (!is_imm && funct7[FUNCT7_ALT]) ? in1 - in2 : in1 + in2;
            F3_SLL:  base_res = in1 << shamt;
            F3_SLT:  base_res = XLEN'($signed(in1) < $signed(in2));
            F3_SLTU: base_res = XLEN'(in1 < in2);
            F3_XOR:  base_res = in1 ^ in2;
            F3_SRL:  base_res = funct7[FUNCT7_ALT] ? XLEN'($signed(in1) >>> shamt)
                                                   : in1 >> shamt;
            F3_OR:   base_res = in1 | in2;
            F3_AND:  base_res = in1 & in2;
            default: base_res = '0;
        endcase
    end

    // 33x33 signed multiply; operand extension selects MULH/MULHSU/MULHU
    always_comb begin
        mul_a   = {(funct3 != F3_MULHU) && in1[XLEN-1], in1};
        mul_b   = {((funct3 == F3_MUL) || (funct3 == F3_MULH)) && in2[XLEN-1], in2};
        prod    = (2*XLEN)'(mul_a * mul_b);
        mul_res = (funct3 == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    assign div_signed  = (funct3 == F3_DIV) || (funct3 == F3_REM);
    assign div_rem_sel = (funct3 == F3_REM) || (funct3 == F3_REMU);

    rv32im_alu_divider u_divider (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .is_signed (div_signed),
        .dividend  (in1),
        .divisor   (in2),
        .quotient  (div_quo),
        .remainder (div_rem),
        .busy      (div_busy),
        .valid     (div_valid)
    );

    // Next-state: the ready cycle is the first cycle of MUL/DIV, so a multiply
    // result is captured on that edge and a divide completes on the 33rd edge.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        div_start = 1'b0;
        if (ready && is_mul) begin
            result_d = mul_res;
            state_d  = HOLD;
        end else if (ready && is_div) begin
            div_start = 1'b1;
            state_d   = DIV;
        end else if (ready) begin
            // A base op aborts anything in flight but leaves the result register alone
            if ((state_q == MUL) || (state_q == DIV)) begin
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                MUL: state_d = HOLD;
                DIV: begin
                    if (div_valid && !div_busy) begin
                        result_d = div_rem_sel ? div_rem : div_quo;
                        state_d  = HOLD;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    // Output select: base ops bypass the FSM entirely
    always_comb begin
        out  = result_q;
        done = 1'b0;
        if (!is_m) begin
            out  = base_res;
            done = 1'b1;
        end else if (!ready) begin
            done = (state_q == IDLE) || (state_q == HOLD);
        end
    end

endmodule

// File: tb/tb_rv32im_alu.sv
// Directed bench for rv32im_alu with a per-cycle behavioural reference model.
module tb_rv32im_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in1, in2;
    logic        is_imm;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        ready;
    logic [31:0] out;
    logic        done;

    int          n_vec = 0;
    int          n_bad = 0;

    // Reference model state: value held after completion and edges still owed
    logic [31:0] m_held;
    logic [31:0] m_pval;
    int          m_pend;

    always #5 clk = ~clk;

    rv32im_alu dut (
        .clk    (clk),
        .rst    (rst),
        .in1    (in1),
        .in2    (in2),
        .is_imm (is_imm),
        .funct3 (funct3),
        .funct7 (funct7),
        .ready  (ready),
        .out    (out),
        .done   (done)
    );

    function automatic logic is_mop(input logic imm, input logic [6:0] f7);
        return !imm && (f7 == 7'b0000001);
    endfunction

    // RISC-V instruction semantics in plain arithmetic
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic imm, input logic [2:0] f3,
                                          input logic [6:0] f7);
        longint          sa, sb;
        longint unsigned ua, ub, up;
        longint          sp;
        int              ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = $signed(a);
        ib = $signed(b);
        if (!is_mop(imm, f7)) begin
            case (f3)
                3'd0: return (!imm && f7[5]) ? a - b : a + b;
                3'd1: return a << b[4:0];
                3'd2: return (ia < ib) ? 32'd1 : 32'd0;
                3'd3: return (a < b) ? 32'd1 : 32'd0;
                3'd4: return a ^ b;
                3'd5: return f7[5] ? 32'(ia >>> b[4:0]) : a >> b[4:0];
                3'd6: return a | b;
                default: return a & b;
            endcase
        end
        case (f3)
            3'd0: begin up = ua * ub; return up[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * longint'(ub); return sp[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            default: begin
                if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
                if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return f3[1] ? 32'd0 : 32'h8000_0000;
                if (!f3[0]) return f3[1] ? 32'(ia % ib) : 32'(ia / ib);
                return f3[1] ? a % b : a / b;
            end
        endcase
    endfunction

    // Model timing: multiply ready after 1 edge, divide after 33
    always @(posedge clk) begin
        if (rst) begin
            m_held = 32'd0;
            m_pend = 0;
        end else if (ready && is_mop(is_imm, funct7)) begin
            m_pval = model(in1, in2, is_imm, funct3, funct7);
            if (!funct3[2]) begin
                m_held = m_pval;
                m_pend = 0;
            end else begin
                m_pend = 32;
            end
        end else if (ready && m_pend > 0) begin
            m_pend = 0;
        end else if (m_pend > 0) begin
            m_pend = m_pend - 1;
            if (m_pend == 0) m_held = m_pval;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        logic        e_done;
        logic [31:0] e_out;
        if (!is_mop(is_imm, funct7)) begin
            e_done = 1'b1;
            e_out  = model(in1, in2, is_imm, funct3, funct7);
        end else begin
            e_done = !ready && (m_pend == 0);
            e_out  = m_held;
        end
        n_vec++;
        if (done !== e_done) begin
            n_bad++;
            $display("FAIL cycle_done t=%0t got %b want %b", $time, done, e_done);
        end
        if (e_done) begin
            n_vec++;
            if (out !== e_out) begin
                n_bad++;
                $display("FAIL cycle_out t=%0t got %08h want %08h", $time, out, e_out);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got %08h want %08h", nm, got, want);
        end
    endtask

    // Issue one instruction (caller positioned just after a rising edge) and
    // check the hand-computed result at the expected latency.
    task automatic op(input logic [31:0] a, input logic [31:0] b, input logic imm,
                      input logic [2:0] f3, input logic [6:0] f7, input int lat,
                      input logic [31:0] want, input string nm);
        in1 = a; in2 = b; is_imm = imm; funct3 = f3; funct7 = f7; ready = 1'b1;
        @(negedge clk);
        if (lat == 0) begin
            chk({nm, "_done"}, {31'd0, done}, 32'd1);
            chk(nm, out, want);
        end else begin
            chk({nm, "_done0"}, {31'd0, done}, 32'd0);
        end
        @(posedge clk); #1;
        ready = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c == lat) begin
                chk({nm, "_done"}, {31'd0, done}, 32'd1);
                chk(nm, out, want);
            end else if (c == lat - 1) begin
                chk({nm, "_early"}, {31'd0, done}, 32'd0);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in1 = '0; in2 = '0; is_imm = 1'b0;
        funct3 = '0; funct7 = '0; ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state: M op without ready shows the cleared result register
        funct7 = 7'b0000001; funct3 = 3'd0;
        @(negedge clk);
        chk("reset_done", {31'd0, done}, 32'd1);
        chk("reset_out", out, 32'd0);
        @(posedge clk); #1;

        // Base ops
        op(32'd5, 32'd7, 1'b0, 3'd0, 7'h00, 0, 32'd12, "add");
        op(32'd5, 32'd7, 1'b0, 3'd0, 7'h20, 0, 32'hFFFF_FFFE, "sub");
        op(32'd5, 32'd7, 1'b1, 3'd0, 7'h20, 0, 32'd12, "addi");
        op(32'h8000_0000, 32'd4, 1'b1, 3'd5, 7'h20, 0, 32'hF800_0000, "srai");
        op(32'h8000_0000, 32'd4, 1'b1, 3'd5, 7'h00, 0, 32'h0800_0000, "srli");
        op(32'hFFFF_FFFF, 32'd1, 1'b0, 3'd2, 7'h00, 0, 32'd1, "slt");
        op(32'hFFFF_FFFF, 32'd1, 1'b0, 3'd3, 7'h00, 0, 32'd0, "sltu");
        op(32'h0000_00F0, 32'd36, 1'b0, 3'd1, 7'h00, 0, 32'h0000_0F00, "sll_mod32");
        op(32'hF0F0_1234, 32'h0FF0_00FF, 1'b0, 3'd4, 7'h00, 0, 32'hFF00_12CB, "xor");
        op(32'hF0F0_1234, 32'h0FF0_00FF, 1'b0, 3'd6, 7'h00, 0, 32'hFFF0_12FF, "or");
        op(32'hF0F0_1234, 32'h0FF0_00FF, 1'b0, 3'd7, 7'h00, 0, 32'h00F0_0034, "and");

        // Multiply
        op(32'hFFFF_FFFF, 32'd2, 1'b0, 3'd0, 7'h01, 1, 32'hFFFF_FFFE, "mul");
        op(32'hFFFF_FFFF, 32'd2, 1'b0, 3'd3, 7'h01, 1, 32'h0000_0001, "mulhu");
        op(32'hFFFF_FFFF, 32'd2, 1'b0, 3'd1, 7'h01, 1, 32'hFFFF_FFFF, "mulh");
        op(32'hFFFF_FFFF, 32'd2, 1'b0, 3'd2, 7'h01, 1, 32'hFFFF_FFFF, "mulhsu");
        op(32'h8000_0000, 32'h8000_0000, 1'b0, 3'd1, 7'h01, 1, 32'h4000_0000, "mulh_min");

        // Divide, including divide-by-zero and overflow
        op(32'hFFFF_FFF9, 32'd2, 1'b0, 3'd4, 7'h01, 33, 32'hFFFF_FFFD, "div");
        op(32'hFFFF_FFF9, 32'd2, 1'b0, 3'd6, 7'h01, 33, 32'hFFFF_FFFF, "rem");
        op(32'd100, 32'd0, 1'b0, 3'd5, 7'h01, 33, 32'hFFFF_FFFF, "divu_zero");
        op(32'd100, 32'd0, 1'b0, 3'd7, 7'h01, 33, 32'd100, "remu_zero");
        op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 3'd4, 7'h01, 33, 32'h8000_0000, "div_ovf");
        op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 3'd6, 7'h01, 33, 32'd0, "rem_ovf");
        op(32'hFFFF_FFFE, 32'd7, 1'b0, 3'd5, 7'h01, 33, 32'h2492_4924, "divu_big");

        // Reset in the middle of a divide
        in1 = 32'hFFFF_FFF9; in2 = 32'd2; is_imm = 1'b0; funct3 = 3'd4; funct7 = 7'h01;
        ready = 1'b1;
        @(posedge clk); #1 ready = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_done", {31'd0, done}, 32'd1);
        chk("rst_mid_out", out, 32'd0);
        @(posedge clk); #1;

        // New ready mid-divide restarts with full latency
        in1 = 32'd100; in2 = 32'd7; funct3 = 3'd4; funct7 = 7'h01; ready = 1'b1;
        @(posedge clk); #1 ready = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        op(32'd20, 32'd3, 1'b0, 3'd5, 7'h01, 33, 32'd6, "restart");

        // Held result stays while the same M op is presented
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("hold_out", out, 32'd6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
